// File: rtl/l2_ctrl_pkg.sv
// l2_ctrl_pkg: shared widths, stream states and helpers
// for the multi-stream buffer L2 controller.
package l2_ctrl_pkg;

  localparam int ADDR_W      = 64;
  localparam int CL_BYTES    = 128;
  localparam int CL_W        = $clog2(CL_BYTES);
  localparam int NSTRMS      = 64;
  localparam int NSTRMS_W    = $clog2(NSTRMS);
  localparam int L2_NSTRMS   = 16;
  localparam int L2_NSTRMS_W = $clog2(L2_NSTRMS);
  localparam int L2_NCL      = 256;
  localparam int L2_NCL_W    = $clog2(L2_NCL);
  localparam int CHANNELS    = NSTRMS / L2_NSTRMS;
  localparam int CHAN_W      = NSTRMS_W - L2_NSTRMS_W;

  typedef logic [1:0] strm_st_t;

  localparam strm_st_t ST_IDLE         = 2'd0;
  localparam strm_st_t ST_NOTIFY_START = 2'd1;
  localparam strm_st_t ST_ACTIVE       = 2'd2;
  localparam strm_st_t ST_NOTIFY_END   = 2'd3;

  function automatic logic [ADDR_W-1:0] line_align(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:CL_W], {CL_W{1'b0}}};
  endfunction

  function automatic logic [CHAN_W-1:0] sid_chan(
    input logic [NSTRMS_W-1:0] sid
  );
    return sid[NSTRMS_W-1:L2_NSTRMS_W];
  endfunction

  function automatic logic [L2_NSTRMS_W-1:0] sid_local(
    input logic [NSTRMS_W-1:0] sid
  );
    return sid[L2_NSTRMS_W-1:0];
  endfunction

endpackage

// File: rtl/l2_ctrl_rr.sv
// l2_rr_arb: round-robin arbiter, priority starts after last grant.
// en_i gates grant and pointer update; req_i/gnt_o one bit per requester.
module l2_rr_arb
  import l2_ctrl_pkg::*;
#(
  parameter int N = NSTRMS,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);

  logic [W-1:0] last_q;
  logic [W-1:0] last_d;
  logic [W-1:0] cand;

  // N is a power of two, so W-bit addition wraps the search
  // around; i = N lands back on last_q, checked last.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = last_q + W'(i);
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o = '0;
    if (en_i && vld_o) gnt_o[idx_o] = 1'b1;
    last_d = (en_i && vld_o) ? idx_o : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= '1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/l2_ctrl.sv
// l2_ctrl: per-stream L2 prefetch controller. Ports: stream start/notify
// (i_rst_*, o_rst_*), L1 reads (i_rd_*), URAM addr (o_addr_*), host req/rsp.
module l2_ctrl
  import l2_ctrl_pkg::*;
#(
  parameter int addr_width       = ADDR_W,
  parameter int cache_line       = CL_BYTES,
  parameter int cache_line_width = $clog2(cache_line),
  parameter int nstrms           = NSTRMS,
  parameter int nstrms_width     = $clog2(nstrms),
  parameter int l2_nstrms        = L2_NSTRMS,
  parameter int l2_nstrms_width  = $clog2(l2_nstrms),
  parameter int l2_ncl           = L2_NCL,
  parameter int l2_ncl_width     = $clog2(l2_ncl),
  parameter int channels         = nstrms / l2_nstrms
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [nstrms-1:0]       i_rst_v,
  output logic [nstrms-1:0]       i_rst_r,
  input  logic [addr_width-1:0]   i_rst_ea_b,
  input  logic [addr_width-1:0]   i_rst_ea_e,
  output logic [nstrms-1:0]       o_rst_v,
  input  logic [nstrms-1:0]       o_rst_r,
  output logic [nstrms-1:0]       o_rst_end,
  input  logic [nstrms-1:0]       i_rd_v,
  output logic [nstrms-1:0]       i_rd_r,
  output logic [channels-1:0]     o_addr_v,
  input  logic [channels-1:0]     o_addr_r,
  output logic [channels*l2_nstrms_width-1:0] o_addr_sid,
  output logic [channels*l2_ncl_width-1:0]    o_addr_ptr,
  output logic                    o_req_v,
  input  logic                    o_req_r,
  output logic [nstrms_width-1:0] o_req_sid,
  output logic [addr_width-1:0]   o_req_ea,
  input  logic                    i_rsp_v,
  output logic                    i_rsp_r,
  input  logic [nstrms_width-1:0] i_rsp_sid
);

  localparam int CW  = l2_ncl_width + 1;
  localparam int SW  = l2_nstrms_width;
  localparam int PW  = l2_ncl_width;
  localparam logic [CW:0] NCL_LIM = (CW+1)'(l2_ncl);

  strm_st_t              st_q      [nstrms];
  strm_st_t              st_d      [nstrms];
  logic [addr_width-1:0] ea_next_q [nstrms];
  logic [addr_width-1:0] ea_next_d [nstrms];
  logic [addr_width-1:0] ea_e_q    [nstrms];
  logic [addr_width-1:0] ea_e_d    [nstrms];
  logic [CW-1:0]         inf_q     [nstrms];
  logic [CW-1:0]         inf_d     [nstrms];
  logic [CW-1:0]         val_q     [nstrms];
  logic [CW-1:0]         val_d     [nstrms];
  logic [PW-1:0]         wptr_q    [nstrms];
  logic [PW-1:0]         wptr_d    [nstrms];
  logic [PW-1:0]         rptr_q    [nstrms];
  logic [PW-1:0]         rptr_d    [nstrms];

  logic [nstrms-1:0] active;
  logic [nstrms-1:0] elig;
  logic [nstrms-1:0] rd_acc;
  logic [nstrms-1:0] rsp_hit;
  logic [nstrms-1:0] gnt;

  logic                    req_en;
  logic                    gnt_vld;
  logic [nstrms_width-1:0] gnt_idx;
  logic                    req_v_q;
  logic [nstrms_width-1:0] req_sid_q;
  logic [addr_width-1:0]   req_ea_q;

  logic [channels-1:0]      slot_free;
  logic [channels-1:0]      ld;
  logic [channels*SW-1:0]   ld_sid;
  logic [channels*PW-1:0]   ld_ptr;
  logic [channels-1:0]      addr_v_q;
  logic [channels*SW-1:0]   addr_sid_q;
  logic [channels*PW-1:0]   addr_ptr_q;

  assign i_rsp_r    = 1'b1;
  assign o_req_v    = req_v_q;
  assign o_req_sid  = req_sid_q;
  assign o_req_ea   = req_ea_q;
  assign o_addr_v   = addr_v_q;
  assign o_addr_sid = addr_sid_q;
  assign o_addr_ptr = addr_ptr_q;

  // A slot can take a new read when empty or drained this cycle.
  assign slot_free = ~addr_v_q | o_addr_r;

  always_comb begin
    for (int s = 0; s < nstrms; s++) begin
      active[s]    = st_q[s] == ST_ACTIVE;
      i_rst_r[s]   = st_q[s] == ST_IDLE;
      o_rst_end[s] = st_q[s] == ST_NOTIFY_END;
      o_rst_v[s]   = st_q[s] == ST_NOTIFY_START ||
                     st_q[s] == ST_NOTIFY_END;
      elig[s]      = active[s] &&
                     ea_next_q[s] < ea_e_q[s] &&
                     ({1'b0, inf_q[s]} + {1'b0, val_q[s]}) < NCL_LIM;
      i_rd_r[s]    = active[s] && val_q[s] != '0 &&
                     slot_free[sid_chan(nstrms_width'(s))];
      rd_acc[s]    = i_rd_v[s] && i_rd_r[s];
      rsp_hit[s]   = i_rsp_v && i_rsp_sid == nstrms_width'(s);
    end
  end

  assign req_en = !req_v_q || o_req_r;

  l2_rr_arb #(
    .N (nstrms),
    .W (nstrms_width)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .en_i  (req_en),
    .req_i (elig),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  always_comb begin
    for (int s = 0; s < nstrms; s++) begin
      st_d[s]      = st_q[s];
      ea_next_d[s] = ea_next_q[s];
      ea_e_d[s]    = ea_e_q[s];
      inf_d[s]     = inf_q[s];
      val_d[s]     = val_q[s];
      wptr_d[s]    = wptr_q[s];
      rptr_d[s]    = rptr_q[s];
      unique case (st_q[s])
        ST_IDLE: begin
          if (i_rst_v[s]) begin
            st_d[s]      = ST_NOTIFY_START;
            ea_next_d[s] = line_align(i_rst_ea_b);
            ea_e_d[s]    = line_align(i_rst_ea_e);
            inf_d[s]     = '0;
            val_d[s]     = '0;
            wptr_d[s]    = '0;
            rptr_d[s]    = '0;
          end
        end
        ST_NOTIFY_START: begin
          if (o_rst_r[s]) st_d[s] = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          // When drained nothing else can move, so the
          // counter updates below are all no-ops then.
          if (ea_next_q[s] == ea_e_q[s] &&
              inf_q[s] == '0 && val_q[s] == '0)
            st_d[s] = ST_NOTIFY_END;
          inf_d[s] = inf_q[s] + CW'(gnt[s]) - CW'(rsp_hit[s]);
          val_d[s] = val_q[s] + CW'(rsp_hit[s]) - CW'(rd_acc[s]);
          if (gnt[s])
            ea_next_d[s] = ea_next_q[s] + addr_width'(cache_line);
          if (rsp_hit[s]) wptr_d[s] = wptr_q[s] + PW'(1);
          if (rd_acc[s])  rptr_d[s] = rptr_q[s] + PW'(1);
        end
        ST_NOTIFY_END: begin
          if (o_rst_r[s]) st_d[s] = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < nstrms; s++) begin
      if (reset) begin
        st_q[s]      <= ST_IDLE;
        ea_next_q[s] <= '0;
        ea_e_q[s]    <= '0;
        inf_q[s]     <= '0;
        val_q[s]     <= '0;
        wptr_q[s]    <= '0;
        rptr_q[s]    <= '0;
      end else begin
        st_q[s]      <= st_d[s];
        ea_next_q[s] <= ea_next_d[s];
        ea_e_q[s]    <= ea_e_d[s];
        inf_q[s]     <= inf_d[s];
        val_q[s]     <= val_d[s];
        wptr_q[s]    <= wptr_d[s];
        rptr_q[s]    <= rptr_d[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_v_q   <= 1'b0;
      req_sid_q <= '0;
      req_ea_q  <= '0;
    end else if (req_en) begin
      req_v_q <= gnt_vld;
      if (gnt_vld) begin
        req_sid_q <= gnt_idx;
        req_ea_q  <= ea_next_q[gnt_idx];
      end
    end
  end

  // L1 requests are one-hot, so at most one stream loads a slot.
  always_comb begin
    ld     = '0;
    ld_sid = '0;
    ld_ptr = '0;
    for (int s = 0; s < nstrms; s++) begin
      if (rd_acc[s]) begin
        ld[sid_chan(nstrms_width'(s))] = 1'b1;
        ld_sid[int'(sid_chan(nstrms_width'(s)))*SW +: SW] =
          sid_local(nstrms_width'(s));
        ld_ptr[int'(sid_chan(nstrms_width'(s)))*PW +: PW] =
          rptr_q[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_v_q   <= '0;
      addr_sid_q <= '0;
      addr_ptr_q <= '0;
    end else begin
      for (int c = 0; c < channels; c++) begin
        if (ld[c]) begin
          addr_v_q[c]            <= 1'b1;
          addr_sid_q[c*SW +: SW] <= ld_sid[c*SW +: SW];
          addr_ptr_q[c*PW +: PW] <= ld_ptr[c*PW +: PW];
        end else if (o_addr_r[c]) begin
          addr_v_q[c] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_ctrl.sv
// tb_l2_ctrl: directed bench for l2_ctrl with host responses
// looped back through a one-cycle register.
module tb_l2_ctrl;
  import l2_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] i_rst_v, i_rst_r, o_rst_v, o_rst_r, o_rst_end;
  logic [63:0] i_rd_v, i_rd_r;
  logic [63:0] ea_b, ea_e;
  logic [3:0]  o_addr_v, o_addr_r;
  logic [15:0] o_addr_sid;
  logic [31:0] o_addr_ptr;
  logic        o_req_v, o_req_r;
  logic [5:0]  o_req_sid;
  logic [63:0] o_req_ea;
  logic        i_rsp_v, i_rsp_r;
  logic [5:0]  i_rsp_sid;

  int n_chk = 0;
  int n_fail = 0;

  logic [5:0]  log_sid [$];
  logic [63:0] log_ea  [$];
  logic [5:0]  rr_exp  [6] = '{6'd2, 6'd17, 6'd1, 6'd2, 6'd17, 6'd1};

  always #5 clk = ~clk;

  l2_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .i_rst_v    (i_rst_v),
    .i_rst_r    (i_rst_r),
    .i_rst_ea_b (ea_b),
    .i_rst_ea_e (ea_e),
    .o_rst_v    (o_rst_v),
    .o_rst_r    (o_rst_r),
    .o_rst_end  (o_rst_end),
    .i_rd_v     (i_rd_v),
    .i_rd_r     (i_rd_r),
    .o_addr_v   (o_addr_v),
    .o_addr_r   (o_addr_r),
    .o_addr_sid (o_addr_sid),
    .o_addr_ptr (o_addr_ptr),
    .o_req_v    (o_req_v),
    .o_req_r    (o_req_r),
    .o_req_sid  (o_req_sid),
    .o_req_ea   (o_req_ea),
    .i_rsp_v    (i_rsp_v),
    .i_rsp_r    (i_rsp_r),
    .i_rsp_sid  (i_rsp_sid)
  );

  // Host memory model: every accepted request returns next cycle.
  always @(posedge clk) begin
    if (reset) begin
      i_rsp_v   <= 1'b0;
      i_rsp_sid <= '0;
    end else begin
      i_rsp_v   <= o_req_v && o_req_r;
      i_rsp_sid <= o_req_sid;
      if (o_req_v && o_req_r) begin
        log_sid.push_back(o_req_sid);
        log_ea.push_back(o_req_ea);
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int cnt_sid(input logic [5:0] sid);
    int n = 0;
    for (int i = 0; i < log_sid.size(); i++)
      if (log_sid[i] == sid) n++;
    return n;
  endfunction

  function automatic logic [63:0] nth_ea(input logic [5:0] sid,
                                         input int n);
    int k = 0;
    for (int i = 0; i < log_sid.size(); i++)
      if (log_sid[i] == sid) begin
        if (k == n) return log_ea[i];
        k++;
      end
    return '1;
  endfunction

  function automatic int seq_bad(input logic [5:0] sid,
                                 input logic [63:0] base);
    int bad = 0;
    logic [63:0] ea = base;
    for (int i = 0; i < log_sid.size(); i++)
      if (log_sid[i] == sid) begin
        if (log_ea[i] != ea) bad++;
        ea = ea + 64'd128;
      end
    return bad;
  endfunction

  initial begin
    int bad_r, bad_a, k, w;
    reset    = 1'b1;
    i_rst_v  = '0;
    o_rst_r  = '0;
    i_rd_v   = '0;
    ea_b     = '0;
    ea_e     = '0;
    o_addr_r = 4'hf;
    o_req_r  = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    chk("rst_i_rst_r", i_rst_r, 64'hffff_ffff_ffff_ffff);
    chk("rst_o_rst_v", o_rst_v, 0);
    chk("rst_o_rst_end", o_rst_end, 0);
    chk("rst_req_v", 64'(o_req_v), 0);
    chk("rst_req_ea", o_req_ea, 0);
    chk("rst_addr_v", 64'(o_addr_v), 0);
    chk("rst_addr_sid", 64'(o_addr_sid), 0);
    chk("rsp_r_tied", 64'(i_rsp_r), 1);

    bad_r = 0;
    bad_a = 0;
    i_rd_v = 64'h2;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i_rd_r[1]) bad_r++;
      if (|o_addr_v) bad_a++;
    end
    i_rd_v = '0;
    chk("rd_r_before_start", 64'(bad_r), 0);
    chk("addr_v_before_start", 64'(bad_a), 0);

    o_req_r = 1'b0;
    i_rst_v = 64'h2;
    ea_b = 64'd32768;
    ea_e = 64'd98304;
    chk("start1_ready", 64'(i_rst_r[1]), 1);
    step();
    i_rst_v = '0;
    chk("start1_notify", o_rst_v, 64'h2);
    chk("start1_end0", o_rst_end, 0);
    step();
    chk("notify_hold", o_rst_v, 64'h2);
    o_rst_r = 64'h2;
    step();
    o_rst_r = '0;
    chk("active1_no_notify", o_rst_v, 0);
    chk("first_req_not_early", 64'(o_req_v), 0);
    step();
    chk("req1_v", 64'(o_req_v), 1);
    chk("req1_sid", 64'(o_req_sid), 1);
    chk("req1_ea", o_req_ea, 64'd32768);
    step();
    chk("req_hold_v", 64'(o_req_v), 1);
    chk("req_hold_ea", o_req_ea, 64'd32768);
    o_req_r = 1'b1;
    step();
    chk("req2_ea", o_req_ea, 64'd32896);

    i_rst_v = 64'h1 << 17;
    ea_b = 64'd131072;
    ea_e = 64'd196608;
    step();
    i_rst_v = 64'h1 << 2;
    ea_b = 64'd262144;
    ea_e = 64'd327680;
    step();
    i_rst_v = '0;
    chk("notify_17_2", o_rst_v, (64'h1 << 17) | (64'h1 << 2));
    o_rst_r = (64'h1 << 17) | (64'h1 << 2);
    step();
    o_rst_r = '0;
    chk("active_17_2", o_rst_v, 0);
    i_rst_v = 64'h2;
    ea_b = 64'd32;
    ea_e = 64'd4096;
    chk("restart_busy_r", 64'(i_rst_r[1]), 0);
    step();
    i_rst_v = '0;
    chk("restart_no_notify", o_rst_v, 0);

    repeat (1000) step();
    k = -1;
    for (int i = 0; i < log_sid.size(); i++)
      if (k < 0 && log_sid[i] != 6'd1) k = i;
    bad_r = 0;
    for (int j = 0; j < 6; j++)
      if (k < 0 || k + j >= log_sid.size() ||
          log_sid[k+j] != rr_exp[j]) bad_r++;
    chk("rr_order", 64'(bad_r), 0);
    chk("first_ea_s2", nth_ea(6'd2, 0), 64'd262144);
    chk("first_ea_s17", nth_ea(6'd17, 0), 64'd131072);
    chk("fill_cnt_s1", 64'(cnt_sid(6'd1)), 256);
    chk("fill_cnt_s2", 64'(cnt_sid(6'd2)), 256);
    chk("fill_cnt_s17", 64'(cnt_sid(6'd17)), 256);
    chk("fill_total", 64'(log_sid.size()), 768);
    chk("stall_req_v", 64'(o_req_v), 0);

    i_rd_v = 64'h2;
    chk("rd1_ready", 64'(i_rd_r[1]), 1);
    step();
    i_rd_v = 64'h1 << 2;
    chk("rd1_addr_v", 64'(o_addr_v), 64'h1);
    chk("rd1_sid", 64'(o_addr_sid[3:0]), 1);
    chk("rd1_ptr", 64'(o_addr_ptr[7:0]), 0);
    step();
    i_rd_v = 64'h1 << 17;
    chk("rd2_addr_v", 64'(o_addr_v), 64'h1);
    chk("rd2_sid", 64'(o_addr_sid[3:0]), 2);
    chk("rd2_ptr", 64'(o_addr_ptr[7:0]), 0);
    step();
    i_rd_v = '0;
    chk("rd17_addr_v", 64'(o_addr_v), 64'h2);
    chk("rd17_sid", 64'(o_addr_sid[7:4]), 1);
    chk("rd17_ptr", 64'(o_addr_ptr[15:8]), 0);
    step();
    chk("rd_drained", 64'(o_addr_v), 0);

    o_addr_r = 4'h0;
    i_rd_v = 64'h2;
    step();
    chk("rd1b_addr_v", 64'(o_addr_v), 64'h1);
    chk("rd1b_ptr", 64'(o_addr_ptr[7:0]), 1);
    chk("rd_r_slot_full", 64'(i_rd_r[1]), 0);
    step();
    chk("addr_hold_v", 64'(o_addr_v), 64'h1);
    chk("addr_hold_ptr", 64'(o_addr_ptr[7:0]), 1);
    i_rd_v = '0;
    o_addr_r = 4'hf;
    step();
    chk("addr_drain", 64'(o_addr_v), 0);

    repeat (20) step();
    chk("refill_cnt_s1", 64'(cnt_sid(6'd1)), 258);
    chk("refill_cnt_s2", 64'(cnt_sid(6'd2)), 257);
    chk("refill_cnt_s17", 64'(cnt_sid(6'd17)), 257);
    chk("seq_ea_s1", 64'(seq_bad(6'd1, 64'd32768)), 0);
    chk("seq_ea_s2", 64'(seq_bad(6'd2, 64'd262144)), 0);
    chk("seq_ea_s17", 64'(seq_bad(6'd17, 64'd131072)), 0);

    i_rst_v = 64'h1 << 5;
    ea_b = 64'd4096;
    ea_e = 64'd4096;
    step();
    i_rst_v = '0;
    chk("empty_notify_v", 64'(o_rst_v[5]), 1);
    chk("empty_notify_end", 64'(o_rst_end[5]), 0);
    o_rst_r = 64'h1 << 5;
    step();
    o_rst_r = '0;
    chk("empty_active", 64'(o_rst_v[5]), 0);
    step();
    chk("empty_end_v", 64'(o_rst_v[5]), 1);
    chk("empty_end_flag", 64'(o_rst_end[5]), 1);
    step();
    chk("empty_end_hold", 64'(o_rst_end[5] & o_rst_v[5]), 1);
    o_rst_r = 64'h1 << 5;
    step();
    o_rst_r = '0;
    chk("empty_idle", 64'(i_rst_r[5]), 1);
    chk("empty_no_notify", 64'(o_rst_v[5]), 0);
    chk("empty_no_req", 64'(cnt_sid(6'd5)), 0);

    i_rst_v = 64'h1 << 6;
    ea_b = 64'd4100;
    ea_e = 64'd4400;
    step();
    i_rst_v = '0;
    chk("s6_notify", 64'(o_rst_v[6]), 1);
    o_rst_r = 64'h1 << 6;
    step();
    o_rst_r = '0;
    repeat (10) step();
    chk("s6_cnt", 64'(cnt_sid(6'd6)), 2);
    chk("s6_ea0", nth_ea(6'd6, 0), 64'd4096);
    chk("s6_ea1", nth_ea(6'd6, 1), 64'd4224);
    i_rd_v = 64'h1 << 6;
    step();
    chk("s6_rd0_sid", 64'(o_addr_sid[3:0]), 6);
    chk("s6_rd0_ptr", 64'(o_addr_ptr[7:0]), 0);
    step();
    i_rd_v = '0;
    chk("s6_rd1_ptr", 64'(o_addr_ptr[7:0]), 1);
    w = 0;
    while (!o_rst_v[6] && w < 10) begin
      step();
      w++;
    end
    chk("s6_end_v", 64'(o_rst_v[6]), 1);
    chk("s6_end_flag", 64'(o_rst_end[6]), 1);
    o_rst_r = 64'h1 << 6;
    step();
    o_rst_r = '0;
    chk("s6_idle", 64'(i_rst_r[6]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
